disp_scan_ctrl: RTL

- Time-multiplexed scanner for the 4-digit common-anode 7-segment display on the Spartan-3E board (0–9999 counter project).
- Accepts a 16-bit packed BCD value from the counter and latches it tear-free at frame boundaries.
- Presents one 4-bit digit code per scan slot to the 7-segment decoder and drives the active-low anodes.
- Provides leading-zero blanking and a global display enable.

---
 rtl/disp_pkg.sv | 43 ++++
 rtl/disp_scan_ctrl_if.sv | 29 ++
 rtl/scan_tick_gen.sv | 31 +++
 rtl/disp_scan_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared constants, types and helpers for the 7-segment scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    localparam int NUM_DIGITS     = 4;
    localparam int TICK_DIV_50MHZ = 50000;
    localparam int CNT_W_50MHZ    = 16;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef logic [3:0]                      digit_t;
    typedef logic [$clog2(NUM_DIGITS)-1:0]   slot_t;

    function automatic digit_t digit_sel(input logic [15:0] v, input slot_t s);
        return v[{s, 2'b00} +: 4];
    endfunction

    // A slot is blanked only when it and every more-significant digit are zero.
    function automatic logic lz_blanked(input logic [15:0] v, input slot_t s, input logic lz);
        logic z;
        case (s)
            2'd3:    z = (v[15:12] == 4'd0);
            2'd2:    z = (v[15:8]  == 8'd0);
            2'd1:    z = (v[15:4]  == 12'd0);
            default: z = 1'b0;
        endcase
        return lz & z;
    endfunction

    function automatic logic [3:0] an_for_slot(input slot_t s);
        return ~(4'b0001 << s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : disp_scan_ctrl_if
//  Description : Value/control inputs and display outputs of the scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
interface disp_scan_ctrl_if;
    import disp_pkg::*;

    logic [15:0] bcd_in;
    logic        load;
    logic        en;
    logic        blank_lz;
    digit_t      num;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    modport master (
        output bcd_in, load, en, blank_lz,
        input  num, an, pending, frame_done
    );

    modport slave (
        input  bcd_in, load, en, blank_lz,
        output num, an, pending, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : scan_tick_gen
//  Description : Free-running prescaler; one-cycle tick every TICK_DIV clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
    parameter int TICK_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : disp_scan_ctrl
//  Description : 4-digit common-anode scanner with frame-aligned value commit
//                and leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_50MHZ,
    parameter int CNT_W    = CNT_W_50MHZ
) (
    input  logic             clk,
    input  logic             rst,
    disp_scan_ctrl_if.slave  bus
);
    logic        w_tick;
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    slot_t       r_slot;
    slot_t       w_slot_nxt;
    logic [15:0] r_shadow;
    logic [15:0] r_active;
    logic [15:0] w_active_nxt;
    logic        w_commit;
    logic        r_pending;
    logic        r_frame_done;
    digit_t      r_num;
    digit_t      w_num_nxt;
    logic [3:0]  r_an;
    logic [3:0]  w_an_nxt;

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        if (!bus.en) begin
            w_state_nxt = ST_OFF;
            w_slot_nxt  = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (w_tick) w_state_nxt = ST_BLANK;
                    w_slot_nxt = '0;
                end
                ST_BLANK: w_state_nxt = ST_DRIVE;
                ST_DRIVE: begin
                    if (w_tick) begin
                        w_state_nxt = ST_BLANK;
                        w_slot_nxt  = r_slot + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                    w_slot_nxt  = '0;
                end
            endcase
        end
    end

    // Commit on the tick leaving slot 3; a coincident load bypasses the shadow.
    assign w_commit = bus.en && (r_state == ST_DRIVE) && (r_slot == 2'd3) && w_tick;

    always_comb begin
        w_active_nxt = r_active;
        if (w_commit) begin
            w_active_nxt = bus.load ? bus.bcd_in : r_shadow;
        end
    end

    // Outputs are computed for the upcoming state so they register in step with it.
    always_comb begin
        w_num_nxt = r_num;
        w_an_nxt  = AN_OFF;
        if (w_state_nxt == ST_BLANK) begin
            w_num_nxt = digit_sel(w_active_nxt, w_slot_nxt);
        end else if (w_state_nxt == ST_DRIVE &&
                     !lz_blanked(w_active_nxt, w_slot_nxt, bus.blank_lz)) begin
            w_an_nxt = an_for_slot(w_slot_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_OFF;
            r_slot       <= '0;
            r_shadow     <= '0;
            r_active     <= '0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_num        <= '0;
            r_an         <= AN_OFF;
        end else begin
            r_state      <= w_state_nxt;
            r_slot       <= w_slot_nxt;
            r_active     <= w_active_nxt;
            r_frame_done <= w_commit;
            r_num        <= w_num_nxt;
            r_an         <= w_an_nxt;
            if (bus.load) r_shadow <= bus.bcd_in;
            if (w_commit) begin
                r_pending <= 1'b0;
            end else if (bus.load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign bus.num        = r_num;
    assign bus.an         = r_an;
    assign bus.pending    = r_pending;
    assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire
